bpsk_frame_ctrl: RTL and testbench

//  Frame sequencer for the BPSK transmit path. Divides clk_sig into symbol ticks.

---
 rtl/bpsk_frame_ctrl_pkg.sv | 36 +++
 rtl/bpsk_frame_ctrl_sym_tick_gen.sv | 27 ++
 rtl/bpsk_frame_ctrl.sv | 116 +++++++++++
 tb/tb_bpsk_frame_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_frame_ctrl_pkg.sv
// Shared phase codes and phase-length helpers for the BPSK frame sequencer.
package bpsk_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_PRE   = 2'd1,
        PH_DATA  = 2'd2,
        PH_GUARD = 2'd3
    } phase_e;

    function automatic phase_e phase_next(input phase_e p);
        case (p)
            PH_PRE:  return PH_DATA;
            PH_DATA: return PH_GUARD;
            default: return PH_IDLE;
        endcase
    endfunction

    // Symbols in the given phase; IDLE reports 1 so the compare stays defined.
    function automatic int phase_len(input phase_e p, input int pre,
                                     input int dat, input int grd);
        case (p)
            PH_PRE:   return pre;
            PH_DATA:  return dat;
            PH_GUARD: return grd;
            default:  return 1;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bpsk_frame_ctrl_sym_tick_gen.sv
// Modulo-N symbol divider with enable and synchronous clear.
module sym_tick_gen #(
    parameter int N = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);
    localparam int DW = $clog2(N);
    localparam logic [DW-1:0] LAST = DW'(N - 1);

    logic [DW-1:0] r_div;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_div <= '0;
        else if (i_clr)
            r_div <= '0;
        else if (i_en)
            r_div <= (r_div == LAST) ? '0 : r_div + 1'b1;
    end

    assign o_tick = i_en && (r_div == LAST);

endmodule

// File: rtl/bpsk_frame_ctrl.sv
// BPSK frame sequencer: PREAMBLE -> DATA -> GUARD with encoder bit pulls.
// Optional frame counter port enabled by defining BPSK_FRAME_CNT_EN.
module bpsk_frame_ctrl
    import bpsk_frame_ctrl_pkg::*;
#(
    parameter int CLK_PER_SYM = 16,
    parameter int PRE_LEN     = 32,
    parameter int DATA_LEN    = 256,
    parameter int GUARD_LEN   = 8
) (
    input  logic clk_sig,
    input  logic reset_sig,
    input  logic start_sig,
    input  logic abort_sig,
    input  logic data_valid_sig,
    output logic sym_tick_sig,
    output logic [1:0] phase_sig,
    output logic data_req_sig,
    output logic [((DATA_LEN > 1) ? $clog2(DATA_LEN) : 1)-1:0] bit_idx_sig,
    output logic underrun_sig,
    output logic busy_sig,
    output logic done_sig
`ifdef BPSK_FRAME_CNT_EN
    , output logic [15:0] frame_cnt_sig
`endif
);
    localparam int MAXL = max3(PRE_LEN, DATA_LEN, GUARD_LEN);
    localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;
    localparam int BW = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;

    phase_e        r_state;
    phase_e        w_next;
    logic [CW-1:0] r_sym_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_tick;
    logic          w_last;
    logic          w_busy;
    int            w_len;

    assign w_busy = (r_state != PH_IDLE);
    assign w_len  = phase_len(r_state, PRE_LEN, DATA_LEN, GUARD_LEN);
    assign w_last = (r_sym_cnt == CW'(w_len - 1));

    // Clearing whenever the next state is IDLE keeps the divider parked at 0.
    sym_tick_gen #(.N(CLK_PER_SYM)) u_tick (
        .i_clk  (clk_sig),
        .i_rst  (reset_sig),
        .i_en   (w_busy),
        .i_clr  (w_next == PH_IDLE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            r_state   <= PH_IDLE;
            r_sym_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_sym_cnt <= w_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_nxt  = r_sym_cnt;
        w_done_nxt = 1'b0;
        unique case (r_state)
            PH_IDLE: begin
                if (start_sig && !abort_sig) begin
                    w_next    = PH_PRE;
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                if (abort_sig) begin
                    w_next    = PH_IDLE;
                    w_cnt_nxt = '0;
                end else if (w_tick) begin
                    if (w_last) begin
                        w_next     = phase_next(r_state);
                        w_cnt_nxt  = '0;
                        w_done_nxt = (r_state == PH_GUARD);
                    end else begin
                        w_cnt_nxt = r_sym_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

`ifdef BPSK_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig)
            r_frame_cnt <= '0;
        else if (w_done_nxt)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt_sig = r_frame_cnt;
`endif

    assign busy_sig     = w_busy;
    assign phase_sig    = r_state;
    assign sym_tick_sig = w_tick;
    assign data_req_sig = w_tick && (r_state == PH_DATA);
    assign underrun_sig = data_req_sig && !data_valid_sig;
    assign bit_idx_sig  = (r_state == PH_DATA) ? BW'(r_sym_cnt) : '0;
    assign done_sig     = r_done;

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Randomized bench for bpsk_frame_ctrl against a frame-offset timeline model.
module tb_bpsk_frame_ctrl;
    localparam int CPS = 4;
    localparam int PRE = 2;
    localparam int DAT = 4;
    localparam int GRD = 1;
    localparam int T   = (PRE + DAT + GRD) * CPS;

    logic clk_sig = 1'b0;
    logic reset_sig;
    logic start_sig;
    logic abort_sig;
    logic data_valid_sig;
    logic sym_tick_sig;
    logic [1:0] phase_sig;
    logic data_req_sig;
    logic [1:0] bit_idx_sig;
    logic underrun_sig;
    logic busy_sig;
    logic done_sig;
`ifdef BPSK_FRAME_CNT_EN
    logic [15:0] frame_cnt_sig;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a frame is just an offset into a fixed timeline of T cycles.
    bit m_act;
    bit m_done;
    int m_off;
    int m_frames;

    int obs_busy, obs_req, obs_und, obs_done, obs_tick;

    always #5 clk_sig = ~clk_sig;

    bpsk_frame_ctrl #(
        .CLK_PER_SYM (CPS),
        .PRE_LEN     (PRE),
        .DATA_LEN    (DAT),
        .GUARD_LEN   (GRD)
    ) dut (
        .clk_sig        (clk_sig),
        .reset_sig      (reset_sig),
        .start_sig      (start_sig),
        .abort_sig      (abort_sig),
        .data_valid_sig (data_valid_sig),
        .sym_tick_sig   (sym_tick_sig),
        .phase_sig      (phase_sig),
        .data_req_sig   (data_req_sig),
        .bit_idx_sig    (bit_idx_sig),
        .underrun_sig   (underrun_sig),
        .busy_sig       (busy_sig),
        .done_sig       (done_sig)
`ifdef BPSK_FRAME_CNT_EN
        , .frame_cnt_sig (frame_cnt_sig)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        int sym, ph, idx;
        bit tk, rq;
        sym = m_off / CPS;
        if (!m_act)                ph = 0;
        else if (sym < PRE)        ph = 1;
        else if (sym < PRE + DAT)  ph = 2;
        else                       ph = 3;
        tk  = m_act && (m_off % CPS == CPS - 1);
        rq  = tk && (ph == 2);
        idx = (ph == 2) ? sym - PRE : 0;
        chk("busy",     busy_sig,     m_act);
        chk("phase",    phase_sig,    ph);
        chk("tick",     sym_tick_sig, tk);
        chk("req",      data_req_sig, rq);
        chk("bit_idx",  bit_idx_sig,  idx);
        chk("underrun", underrun_sig, rq && !data_valid_sig);
        chk("done",     done_sig,     m_done);
`ifdef BPSK_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt_sig, m_frames & 16'hFFFF);
`endif
    endtask

    task automatic model_edge(input bit st, input bit ab);
        m_done = 1'b0;
        if (!m_act) begin
            if (st && !ab) begin
                m_act = 1'b1;
                m_off = 0;
            end
        end else if (ab) begin
            m_act = 1'b0;
        end else if (m_off == T - 1) begin
            m_act  = 1'b0;
            m_done = 1'b1;
            m_frames++;
        end else begin
            m_off++;
        end
    endtask

    task automatic cycle(input bit st, input bit ab, input bit vl);
        start_sig      = st;
        abort_sig      = ab;
        data_valid_sig = vl;
        @(negedge clk_sig);
        check_outputs();
        obs_busy += busy_sig;
        obs_req  += data_req_sig;
        obs_und  += underrun_sig;
        obs_done += done_sig;
        obs_tick += sym_tick_sig;
        @(posedge clk_sig);
        model_edge(st, ab);
        #1;
    endtask

    task automatic clr_obs();
        obs_busy = 0; obs_req = 0; obs_und = 0; obs_done = 0; obs_tick = 0;
    endtask

    task automatic full_frame(input string tag);
        clr_obs();
        cycle(1, 0, 1);
        repeat (T + 3) cycle(0, 0, 1);
        chk({tag, "_busy_len"}, obs_busy, T);
        chk({tag, "_ticks"},    obs_tick, PRE + DAT + GRD);
        chk({tag, "_reqs"},     obs_req,  DAT);
        chk({tag, "_done"},     obs_done, 1);
    endtask

    initial begin
        reset_sig = 1'b1;
        start_sig = 1'b0;
        abort_sig = 1'b0;
        data_valid_sig = 1'b0;
        m_act = 0; m_done = 0; m_off = 0; m_frames = 0;
        repeat (2) @(posedge clk_sig);
        #1;
        check_outputs();
        reset_sig = 1'b0;

        full_frame("nominal");

        clr_obs();
        cycle(1, 0, 1);
        for (int i = 0; i < T + 3; i++)
            cycle(0, 0, i != (PRE + 2) * CPS + CPS - 1);
        chk("under_pulses", obs_und,  1);
        chk("under_len",    obs_busy, T);
        chk("under_done",   obs_done, 1);

        clr_obs();
        cycle(1, 0, 1);
        for (int i = 0; i < T + 3; i++)
            cycle(0, i == (PRE + 1) * CPS + CPS - 1, 1);
        chk("abort_len",  obs_busy, (PRE + 2) * CPS);
        chk("abort_done", obs_done, 0);
        chk("abort_reqs", obs_req,  2);
        full_frame("after_abort");

        clr_obs();
        cycle(1, 0, 1);
        for (int i = 0; i < T + 3; i++)
            cycle(i == 2, 0, 1);
        chk("busy_start_done", obs_done, 1);
        chk("busy_start_len",  obs_busy, T);
        clr_obs();
        cycle(1, 1, 1);
        repeat (4) cycle(0, 0, 1);
        chk("start_abort_busy", obs_busy, 0);

        cycle(1, 0, 1);
        repeat (PRE * CPS + 5) cycle(0, 0, 1);
        @(negedge clk_sig);
        #1 reset_sig = 1'b1;
        m_act = 0; m_done = 0; m_off = 0; m_frames = 0;
        #1 check_outputs();
        reset_sig = 1'b0;
        @(posedge clk_sig);
        #1;
        clr_obs();
        repeat (8) cycle(0, 0, 1);
        chk("post_reset_idle", obs_busy, 0);
        full_frame("post_reset");

`ifdef BPSK_FRAME_CNT_EN
        force dut.r_frame_cnt = 16'hFFFE;
        #1 release dut.r_frame_cnt;
        m_frames = 16'hFFFE;
        full_frame("cnt1");
        full_frame("cnt2");
        chk("cnt_wrap", frame_cnt_sig, 16'h0000);
        cycle(1, 0, 1);
        for (int i = 0; i < T + 3; i++)
            cycle(0, i == 5, 1);
        chk("cnt_abort", frame_cnt_sig, 16'h0000);
`endif

        repeat (3000)
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 7) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
